// File: rtl/mc_pkg.sv
// mc_pkg: shared definitions for the multicycle control unit.
//   - state_t     : controller states (4-bit, also driven on the debug port)
//   - OP_*        : RV64I major opcodes handled by the controller
//   - F3_* / F7_* : funct3 / funct7 values needed for decode
//   - ALU_*       : ALU control codes (also used by the ALU itself)
//   - SRC_A_* / SRC_B_* : operand-mux select encodings
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXEC_R   = 4'd2,
        EXEC_I   = 4'd3,
        R_WB     = 4'd4,
        MEM_ADDR = 4'd5,
        MEM_RD   = 4'd6,
        MEM_WB   = 4'd7,
        MEM_WR   = 4'd8,
        BRANCH   = 4'd9
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [2:0] F3_ADDSUB = 3'b000;
    localparam logic [2:0] F3_XOR    = 3'b100;
    localparam logic [2:0] F3_OR     = 3'b110;
    localparam logic [2:0] F3_AND    = 3'b111;
    localparam logic [2:0] F3_DOUBLE = 3'b011;
    localparam logic [2:0] F3_BEQ    = 3'b000;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_SUB    = 7'b0100000;

    localparam logic [3:0] ALU_AND   = 4'b0000;
    localparam logic [3:0] ALU_OR    = 4'b0001;
    localparam logic [3:0] ALU_ADD   = 4'b0010;
    localparam logic [3:0] ALU_XOR   = 4'b0101;
    localparam logic [3:0] ALU_SUB   = 4'b0110;

    localparam logic [1:0] SRC_A_PC     = 2'b00;
    localparam logic [1:0] SRC_A_REG    = 2'b01;
    localparam logic [1:0] SRC_A_OLD_PC = 2'b10;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_FOUR   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;

endpackage

// File: rtl/mc_alu_decode.sv
// mc_alu_decode: combinational instruction decoder.
// Maps opcode/funct3/funct7 to the ALU operation the instruction needs and
// flags whether the instruction belongs to the supported subset.
//   opcode  in  7 : instr[6:0]
//   funct3  in  3 : instr[14:12]
//   funct7  in  7 : instr[31:25]
//   alu_ctl out 4 : ALU operation (add when not otherwise meaningful)
//   legal   out 1 : 1 when the instruction is supported
module mc_alu_decode
    import mc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [3:0] alu_ctl,
    output logic       legal
);

    always_comb begin
        alu_ctl = ALU_ADD;
        legal   = 1'b0;
        case (opcode)
            OP_R: begin
                if (funct7 == F7_BASE) begin
                    case (funct3)
                        F3_ADDSUB: begin legal = 1'b1; alu_ctl = ALU_ADD; end
                        F3_XOR:    begin legal = 1'b1; alu_ctl = ALU_XOR; end
                        F3_OR:     begin legal = 1'b1; alu_ctl = ALU_OR;  end
                        F3_AND:    begin legal = 1'b1; alu_ctl = ALU_AND; end
                        default:   ;
                    endcase
                end else if (funct7 == F7_SUB && funct3 == F3_ADDSUB) begin
                    legal   = 1'b1;
                    alu_ctl = ALU_SUB;
                end
            end
            OP_I: begin
                case (funct3)
                    F3_ADDSUB: begin legal = 1'b1; alu_ctl = ALU_ADD; end
                    F3_OR:     begin legal = 1'b1; alu_ctl = ALU_OR;  end
                    default:   ;
                endcase
            end
            // Only the doubleword forms (ld/sd) are supported.
            OP_LOAD, OP_STORE: legal = (funct3 == F3_DOUBLE);
            OP_BRANCH: begin
                if (funct3 == F3_BEQ) begin
                    legal   = 1'b1;
                    alu_ctl = ALU_SUB;
                end
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// mc_control: multicycle control unit for the RV64I-subset datapath.
// Sequences fetch/decode/execute/memory/writeback and drives the ALU code,
// operand selects and datapath write enables.
//   clk, rst_n        : clock, asynchronous active-low reset
//   instr      in 32  : instruction register (stable from DECODE onward)
//   zero       in 1   : ALU zero flag, resolves beq in BRANCH
//   mem_ready  in 1   : memory access completes in the cycle it is 1
//   alu_ctl    out 4  : ALU operation code
//   alu_src_a  out 2  : operand A select (PC / reg A / old PC)
//   alu_src_b  out 2  : operand B select (reg B / 4 / immediate)
//   pc_source  out 1  : next PC from ALU result (0) or ALUOut (1)
//   pc_en      out 1  : PC write enable
//   old_pc_write, ir_write, i_or_d, mem_read, mem_write,
//   reg_write, mem_to_reg : datapath controls
//   illegal    out 1  : one-cycle pulse in DECODE for unsupported instructions
//   state      out 4  : current state (debug)
module mc_control
    import mc_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] instr,
    input  logic        zero,
    input  logic        mem_ready,
    output logic [3:0]  alu_ctl,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        pc_source,
    output logic        pc_en,
    output logic        old_pc_write,
    output logic        ir_write,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        illegal,
    output logic [3:0]  state
);

    state_t     state_q;
    state_t     state_d;
    logic [3:0] dec_ctl;
    logic       dec_legal;
    logic       pc_write;
    logic       pc_write_cond;

    // Operand/destination register fields are consumed by the datapath only.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{instr[24:15], instr[11:7]};

    mc_alu_decode u_alu_decode (
        .opcode  (instr[6:0]),
        .funct3  (instr[14:12]),
        .funct7  (instr[31:25]),
        .alu_ctl (dec_ctl),
        .legal   (dec_legal)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs decode from the state register. The whole decode sits under
    // rst_n so that asserting reset mid-instruction drops every enable in
    // the same instant the state register is cleared.
    always_comb begin
        state_d       = state_q;
        alu_ctl       = ALU_ADD;
        alu_src_a     = SRC_A_PC;
        alu_src_b     = SRC_B_REG;
        pc_source     = 1'b0;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        old_pc_write  = 1'b0;
        ir_write      = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        illegal       = 1'b0;

        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    mem_read     = 1'b1;
                    alu_src_a    = SRC_A_PC;
                    alu_src_b    = SRC_B_FOUR;
                    // Instruction, PC+4 and old PC are captured together
                    // in the cycle the fetch completes.
                    ir_write     = mem_ready;
                    pc_write     = mem_ready;
                    old_pc_write = mem_ready;
                    if (mem_ready) begin
                        state_d = DECODE;
                    end
                end
                DECODE: begin
                    // old PC + imm: branch target lands in ALUOut.
                    alu_src_a = SRC_A_OLD_PC;
                    alu_src_b = SRC_B_IMM;
                    if (!dec_legal) begin
                        illegal = 1'b1;
                        state_d = FETCH;
                    end else begin
                        case (instr[6:0])
                            OP_R:              state_d = EXEC_R;
                            OP_I:              state_d = EXEC_I;
                            OP_LOAD, OP_STORE: state_d = MEM_ADDR;
                            OP_BRANCH:         state_d = BRANCH;
                            default:           state_d = FETCH;
                        endcase
                    end
                end
                EXEC_R: begin
                    alu_src_a = SRC_A_REG;
                    alu_src_b = SRC_B_REG;
                    alu_ctl   = dec_ctl;
                    state_d   = R_WB;
                end
                EXEC_I: begin
                    alu_src_a = SRC_A_REG;
                    alu_src_b = SRC_B_IMM;
                    alu_ctl   = dec_ctl;
                    state_d   = R_WB;
                end
                R_WB: begin
                    reg_write = 1'b1;
                    state_d   = FETCH;
                end
                MEM_ADDR: begin
                    alu_src_a = SRC_A_REG;
                    alu_src_b = SRC_B_IMM;
                    // Store opcode differs from load only in bit 5.
                    state_d   = instr[5] ? MEM_WR : MEM_RD;
                end
                MEM_RD: begin
                    i_or_d   = 1'b1;
                    mem_read = 1'b1;
                    if (mem_ready) begin
                        state_d = MEM_WB;
                    end
                end
                MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = FETCH;
                end
                MEM_WR: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                    if (mem_ready) begin
                        state_d = FETCH;
                    end
                end
                BRANCH: begin
                    alu_src_a     = SRC_A_REG;
                    alu_src_b     = SRC_B_REG;
                    alu_ctl       = ALU_SUB;
                    pc_write_cond = 1'b1;
                    pc_source     = 1'b1;
                    state_d       = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    assign pc_en = pc_write | (pc_write_cond & zero);
    assign state = state_q;

endmodule

// File: tb/tb_mc_control.sv
// tb_mc_control: self-checking bench for mc_control.
module tb_mc_control;
    import mc_pkg::*;

    logic        clk;
    logic        rst_n;
    logic [31:0] instr;
    logic        zero;
    logic        mem_ready;
    logic [3:0]  alu_ctl;
    logic [1:0]  alu_src_a;
    logic [1:0]  alu_src_b;
    logic        pc_source;
    logic        pc_en;
    logic        old_pc_write;
    logic        ir_write;
    logic        i_or_d;
    logic        mem_read;
    logic        mem_write;
    logic        reg_write;
    logic        mem_to_reg;
    logic        illegal;
    logic [3:0]  state;

    int n_checks = 0;
    int n_err    = 0;

    mc_control dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .instr        (instr),
        .zero         (zero),
        .mem_ready    (mem_ready),
        .alu_ctl      (alu_ctl),
        .alu_src_a    (alu_src_a),
        .alu_src_b    (alu_src_b),
        .pc_source    (pc_source),
        .pc_en        (pc_en),
        .old_pc_write (old_pc_write),
        .ir_write     (ir_write),
        .i_or_d       (i_or_d),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .reg_write    (reg_write),
        .mem_to_reg   (mem_to_reg),
        .illegal      (illegal),
        .state        (state)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- observed output bundle ----------------
    typedef struct packed {
        logic [3:0] ctl;
        logic [1:0] a;
        logic [1:0] b;
        logic       ps;
        logic       pc_en;
        logic       opw;
        logic       irw;
        logic       iod;
        logic       mrd;
        logic       mw;
        logic       rw;
        logic       m2r;
        logic       ill;
        logic [3:0] st;
    } obs_t;

    obs_t act;
    assign act = {alu_ctl, alu_src_a, alu_src_b, pc_source, pc_en, old_pc_write,
                  ir_write, i_or_d, mem_read, mem_write, reg_write, mem_to_reg,
                  illegal, state};

    // ---------------- reference model ----------------
    localparam int M_ILL  = 0;
    localparam int M_ADD  = 1;
    localparam int M_SUB  = 2;
    localparam int M_AND  = 3;
    localparam int M_OR   = 4;
    localparam int M_XOR  = 5;
    localparam int M_ADDI = 6;
    localparam int M_ORI  = 7;
    localparam int M_LD   = 8;
    localparam int M_SD   = 9;
    localparam int M_BEQ  = 10;

    function automatic int classify(logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd0) return M_ADD;
        if (op == 7'h33 && f7 == 7'h20 && f3 == 3'd0) return M_SUB;
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd4) return M_XOR;
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd6) return M_OR;
        if (op == 7'h33 && f7 == 7'h00 && f3 == 3'd7) return M_AND;
        if (op == 7'h13 && f3 == 3'd0) return M_ADDI;
        if (op == 7'h13 && f3 == 3'd6) return M_ORI;
        if (op == 7'h03 && f3 == 3'd3) return M_LD;
        if (op == 7'h23 && f3 == 3'd3) return M_SD;
        if (op == 7'h63 && f3 == 3'd0) return M_BEQ;
        return M_ILL;
    endfunction

    function automatic logic [3:0] op_code(int mn);
        case (mn)
            M_SUB, M_BEQ: return 4'b0110;
            M_AND:        return 4'b0000;
            M_OR, M_ORI:  return 4'b0001;
            M_XOR:        return 4'b0101;
            default:      return 4'b0010;
        endcase
    endfunction

    // What each step of an instruction drives; anything not set is 0.
    function automatic obs_t exp_out(state_t ph, int mn, logic mr, logic z);
        obs_t o;
        o     = '0;
        o.ctl = 4'b0010;
        o.st  = ph;
        case (ph)
            FETCH:    begin o.b = 2'b01; o.mrd = 1'b1; o.pc_en = mr; o.opw = mr; o.irw = mr; end
            DECODE:   begin o.a = 2'b10; o.b = 2'b10; o.ill = (mn == M_ILL); end
            EXEC_R:   begin o.a = 2'b01; o.b = 2'b00; o.ctl = op_code(mn); end
            EXEC_I:   begin o.a = 2'b01; o.b = 2'b10; o.ctl = op_code(mn); end
            R_WB:     o.rw = 1'b1;
            MEM_ADDR: begin o.a = 2'b01; o.b = 2'b10; end
            MEM_RD:   begin o.iod = 1'b1; o.mrd = 1'b1; end
            MEM_WB:   begin o.rw = 1'b1; o.m2r = 1'b1; end
            MEM_WR:   begin o.iod = 1'b1; o.mw = 1'b1; end
            BRANCH:   begin o.a = 2'b01; o.b = 2'b00; o.ctl = 4'b0110; o.ps = 1'b1; o.pc_en = z; end
            default:  ;
        endcase
        return o;
    endfunction

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Runs one instruction from FETCH back to FETCH, comparing every cycle
    // against the model. mode 0: mem_ready=1, zero=zfix. mode 1: random
    // mem_ready/zero. mode 2: mem_ready low for the first 2 memory-wait cycles.
    // Called right at a falling edge; returns at a falling edge.
    task automatic run_instr(input logic [31:0] ins, input int mode, input logic zfix,
                             output int cycles, output logic [3:0] ctl3,
                             output logic late_pc_en);
        state_t ph_q[$];
        int     mn;
        int     idx;
        int     stall_left;
        logic   mr;
        logic   z;
        obs_t   e;
        mn = classify(ins);
        ph_q.push_back(FETCH);
        ph_q.push_back(DECODE);
        case (mn)
            M_ADD, M_SUB, M_AND, M_OR, M_XOR: begin ph_q.push_back(EXEC_R); ph_q.push_back(R_WB); end
            M_ADDI, M_ORI: begin ph_q.push_back(EXEC_I); ph_q.push_back(R_WB); end
            M_LD: begin ph_q.push_back(MEM_ADDR); ph_q.push_back(MEM_RD); ph_q.push_back(MEM_WB); end
            M_SD: begin ph_q.push_back(MEM_ADDR); ph_q.push_back(MEM_WR); end
            M_BEQ: ph_q.push_back(BRANCH);
            default: ;
        endcase
        instr      = ins;
        idx        = 0;
        cycles     = 0;
        stall_left = 2;
        ctl3       = 4'b0000;
        late_pc_en = 1'b0;
        while (idx < ph_q.size()) begin
            case (mode)
                1: begin
                    mr = ($urandom_range(0, 2) != 0) || (cycles > 40);
                    z  = 1'($urandom_range(0, 1));
                end
                2: begin
                    mr = !((ph_q[idx] == MEM_RD || ph_q[idx] == MEM_WR) && stall_left > 0);
                    if (!mr) stall_left--;
                    z = zfix;
                end
                default: begin
                    mr = 1'b1;
                    z  = zfix;
                end
            endcase
            mem_ready = mr;
            zero      = z;
            #1;
            e = exp_out(ph_q[idx], mn, mr, z);
            check("cycle_outputs", 32'(act), 32'(e));
            if (cycles == 2) ctl3 = alu_ctl;
            if (cycles > 0)  late_pc_en = late_pc_en | pc_en;
            if (!((ph_q[idx] == FETCH || ph_q[idx] == MEM_RD || ph_q[idx] == MEM_WR) && !mr)) begin
                idx++;
            end
            cycles++;
            @(negedge clk);
        end
    endtask

    // ---------------- directed table ----------------
    typedef struct {
        logic [31:0] instr;
        logic        zero;
        int          cycles;
        logic [3:0]  ctl3;
        logic        late_pc_en;
    } vec_t;

    vec_t tbl[14];

    initial begin
        int         cyc;
        logic [3:0] c3;
        logic       lpe;
        obs_t       rv;
        logic [31:0] pool[14];

        tbl[0]  = '{32'h002081B3, 1'b1, 4, 4'b0010, 1'b0}; // add
        tbl[1]  = '{32'h402081B3, 1'b0, 4, 4'b0110, 1'b0}; // sub
        tbl[2]  = '{32'h0020C1B3, 1'b1, 4, 4'b0101, 1'b0}; // xor
        tbl[3]  = '{32'h0020E1B3, 1'b0, 4, 4'b0001, 1'b0}; // or
        tbl[4]  = '{32'h0020F1B3, 1'b1, 4, 4'b0000, 1'b0}; // and
        tbl[5]  = '{32'h0010E193, 1'b0, 4, 4'b0001, 1'b0}; // ori
        tbl[6]  = '{32'h00108193, 1'b1, 4, 4'b0010, 1'b0}; // addi
        tbl[7]  = '{32'h0000B183, 1'b1, 5, 4'b0010, 1'b0}; // ld
        tbl[8]  = '{32'h0030B023, 1'b1, 4, 4'b0010, 1'b0}; // sd
        tbl[9]  = '{32'h00208463, 1'b1, 3, 4'b0110, 1'b1}; // beq taken
        tbl[10] = '{32'h00208463, 1'b0, 3, 4'b0110, 1'b0}; // beq not taken
        tbl[11] = '{32'h0000007F, 1'b1, 2, 4'b0000, 1'b0}; // bad opcode
        tbl[12] = '{32'h022081B3, 1'b0, 2, 4'b0000, 1'b0}; // R-type funct7=01
        tbl[13] = '{32'h0000A183, 1'b0, 2, 4'b0000, 1'b0}; // lw: not supported

        rv     = '0;
        rv.ctl = 4'b0010;
        rv.st  = FETCH;

        // ---- reset: outputs gated even with mem_ready/zero high ----
        rst_n     = 1'b0;
        instr     = 32'h002081B3;
        zero      = 1'b1;
        mem_ready = 1'b1;
        #3;
        check("reset_outputs", 32'(act), 32'(rv));
        @(negedge clk);
        rst_n = 1'b1;

        // ---- directed table, mem_ready held high ----
        for (int i = 0; i < 14; i++) begin
            run_instr(tbl[i].instr, 0, tbl[i].zero, cyc, c3, lpe);
            check($sformatf("cycles_%0d", i), 32'(cyc), 32'(tbl[i].cycles));
            if (tbl[i].cycles > 2) check($sformatf("alu_ctl_%0d", i), 32'(c3), 32'(tbl[i].ctl3));
            check($sformatf("late_pc_en_%0d", i), 32'(lpe), 32'(tbl[i].late_pc_en));
        end

        // ---- ld with two stall cycles in MEM_RD ----
        run_instr(32'h0000B183, 2, 1'b0, cyc, c3, lpe);
        check("ld_stall_cycles", 32'(cyc), 32'd7);

        // ---- sd with two stall cycles in MEM_WR ----
        run_instr(32'h0030B023, 2, 1'b0, cyc, c3, lpe);
        check("sd_stall_cycles", 32'(cyc), 32'd6);

        // ---- reset asserted during MEM_WR ----
        instr     = 32'h0030B023;
        mem_ready = 1'b1;
        zero      = 1'b0;
        repeat (3) @(negedge clk);
        mem_ready = 1'b0;
        #1;
        check("wr_state", 32'(state), 32'(MEM_WR));
        check("wr_mem_write", 32'(mem_write), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rst_mem_write", 32'(mem_write), 32'd0);
        check("rst_state", 32'(state), 32'(FETCH));
        check("rst_outputs", 32'(act), 32'(rv));
        mem_ready = 1'b1;
        @(posedge clk);
        #1;
        check("rst_hold_outputs", 32'(act), 32'(rv));
        @(negedge clk);
        mem_ready = 1'b0;
        rst_n     = 1'b1;
        #1;
        check("resume_mem_read", 32'(mem_read), 32'd1);
        check("resume_state", 32'(state), 32'(FETCH));
        @(negedge clk);
        run_instr(32'h002081B3, 0, 1'b0, cyc, c3, lpe);
        check("resume_add_cycles", 32'(cyc), 32'd4);

        // ---- randomized instructions and handshakes ----
        for (int i = 0; i < 14; i++) pool[i] = tbl[i].instr;
        for (int i = 0; i < 200; i++) begin
            logic [31:0] w;
            if ($urandom_range(0, 7) == 0) w = $urandom;
            else w = pool[$urandom_range(0, 13)];
            run_instr(w, 1, 1'b0, cyc, c3, lpe);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    // Overall time limit.
    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, errors=%0d", n_err);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/mc_control.md
# mc_control

Multicycle control unit for the 64-bit RV64I-subset processor. Sits directly upstream of the ALU: it sequences each instruction through fetch/decode/execute/memory/writeback, and drives the ALU operation code, operand-mux selects and all datapath write enables. It consumes the ALU `zero` flag to resolve `beq`. Supported instructions: `add`, `sub`, `and`, `or`, `xor`, `addi`, `ori`, `ld`, `sd`, `beq`.

## Interface
- No parameters. Encodings are fixed in the package.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr` in 32: instruction register contents, stable from DECODE onward.
- `zero` in 1: ALU zero flag (combinational, same cycle).
- `mem_ready` in 1: memory handshake; access completes in the cycle it is 1.
- `alu_ctl` out 4: ALU operation code. `add`=0010, `sub`=0110, `and`=0000, `or`=0001, `xor`=0101.
- `alu_src_a` out 2: operand A select. 00=PC, 01=reg A, 10=old PC.
- `alu_src_b` out 2: operand B select. 00=reg B, 01=constant 4, 10=immediate.
- `pc_source` out 1: next-PC select. 0=ALU result, 1=ALUOut register.
- `pc_en` out 1: PC write enable, equal to `pc_write | (pc_write_cond & zero)`.
- `old_pc_write`, `ir_write` out 1 each: latch the old PC and the instruction.
- `i_or_d` out 1: memory address select. 0=PC, 1=ALUOut.
- `mem_read`, `mem_write` out 1 each.
- `reg_write`, `mem_to_reg` out 1 each: register-file write enable and writeback-source select.
- `illegal` out 1: one-cycle pulse on an undecodable instruction.
- `state` out 4: current state, for debug.

## Operation
- Moore FSM. Outputs decode from the state register; only `pc_en` depends on `zero`. Any output not listed for a state is 0. Default `alu_ctl` is `add`.
- **FETCH**
  - Outputs: `mem_read`=1, `i_or_d`=0, A=PC, B=4, `add`, `pc_source`=0.
  - `ir_write`, `pc_write` and `old_pc_write` equal `mem_ready`.
  - Stays in FETCH while `mem_ready`=0, then goes to DECODE.
- **DECODE**
  - Outputs: A=old PC, B=imm, `add`. The datapath captures the branch target in ALUOut.
  - Next state by opcode:
    - 0110011 → EXEC_R
    - 0010011 → EXEC_I
    - 0000011 or 0100011 with funct3=011 → MEM_ADDR
    - 1100011 with funct3=000 → BRANCH
    - anything else → FETCH, with `illegal`=1 for that cycle
  - R-type must be funct7/funct3 ∈ {0000000/000, 0100000/000, 0000000/100, 0000000/110, 0000000/111}; otherwise illegal.
  - I-type must be funct3 ∈ {000, 110}; otherwise illegal.
- **EXEC_R**: A=reg A, B=reg B, `alu_ctl` from funct → R_WB.
- **EXEC_I**: A=reg A, B=imm, `add` (000) or `or` (110) → R_WB.
- **R_WB**: `reg_write`=1, `mem_to_reg`=0 → FETCH.
- **MEM_ADDR**: A=reg A, B=imm, `add` → MEM_RD for `ld`, MEM_WR for `sd`.
- **MEM_RD**: `i_or_d`=1, `mem_read`=1. Waits for `mem_ready`, then → MEM_WB.
- **MEM_WB**: `reg_write`=1, `mem_to_reg`=1 → FETCH.
- **MEM_WR**: `i_or_d`=1, `mem_write`=1. Waits for `mem_ready`, then → FETCH.
- **BRANCH**: A=reg A, B=reg B, `sub`, `pc_write_cond`=1, `pc_source`=1 → FETCH. `pc_en`=`zero`.
- `pc_write` and `pc_write_cond` are internal terms; they are never asserted in the same state.

## Timing
- Reset:
  - While `rst_n`=0, the state is forced to FETCH.
  - All enables (`pc_en`, `old_pc_write`, `ir_write`, `mem_read`, `mem_write`, `reg_write`) are gated to 0; `illegal`=0.
  - Selects read 0 and `alu_ctl`=0010.
  - Deassertion is synchronised externally; the first FETCH cycle follows the first rising edge after release.
- Reset asserted mid-instruction aborts immediately, with no pending write completing.
- Cycle counts with `mem_ready` held at 1:
  - `beq`: 3 cycles
  - R-type, I-type, `sd`: 4 cycles
  - `ld`: 5 cycles
- Each cycle `mem_ready` is low in FETCH, MEM_RD or MEM_WR adds one cycle; every output holds steady through the wait.
- `mem_ready` is ignored in every other state.
- `illegal` costs 2 cycles total (FETCH + DECODE), with no register or memory write.

## Structure
- Package `mc_pkg` holds:
  - state enum: FETCH, DECODE, EXEC_R, EXEC_I, R_WB, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH
  - opcode constants
  - ALU control codes, also imported by the ALU
  - `alu_src_a`/`alu_src_b` select encodings
- One combinational sub-module, `mc_alu_decode`: maps opcode/funct3/funct7 to `alu_ctl` plus a `legal` flag. Used by both DECODE and the EXEC states.

## Test plan
- `add` (instr 0x002081B3), `mem_ready`=1:
  - state sequence FETCH, DECODE, EXEC_R, R_WB
  - `alu_ctl` 0010 in EXEC_R
  - `reg_write`=1 only in R_WB
  - `pc_en`=1 only in FETCH
- `sub` (0x402081B3) → `alu_ctl`=0110. `xor`/`or`/`and` → 0101/0001/0000. `ori` (0x0010E193) → 0001 with B=imm.
- `ld` (0x0000B183) with `mem_ready` low for 2 cycles in MEM_RD:
  - 7 cycles total
  - `mem_read` and `i_or_d`=1 held through the stall
  - `mem_to_reg`=1 in MEM_WB
- `beq` (0x00208463):
  - `zero`=1 in BRANCH → `pc_en`=1, `pc_source`=1
  - `zero`=0 → `pc_en`=0
  - returns to FETCH after 3 cycles
- Illegal opcode 0x0000007F and R-type funct7 0x01:
  - `illegal` pulses 1 cycle in DECODE
  - next state FETCH
  - no write enables asserted
- Assert `rst_n`=0 during MEM_WR:
  - `mem_write` drops to 0 asynchronously
  - state becomes FETCH
  - after release, fetch resumes with `mem_read`=1
